// File: rtl/trap_pkg.sv
// Shared codes for the trap arbiter: CPU state encodings, privilege levels,
// cause codes, exc_vec/mip bit positions and the arbiter FSM states.
package trap_pkg;

   localparam logic [3:0] ST_IF0  = 4'b0000;
   localparam logic [3:0] ST_EX0  = 4'b0001;
   localparam logic [3:0] ST_MEM0 = 4'b0010;
   localparam logic [3:0] ST_WB   = 4'b0011;
   localparam logic [3:0] ST_EX1  = 4'b1001;
   localparam logic [3:0] ST_MEM1 = 4'b1010;
   localparam logic [3:0] ST_EXC  = 4'b1111;

   localparam logic [1:0] PRIV_U = 2'b00;
   localparam logic [1:0] PRIV_S = 2'b01;
   localparam logic [1:0] PRIV_M = 2'b11;

   localparam logic [4:0] EXC_IAM = 5'd0;
   localparam logic [4:0] EXC_IAF = 5'd1;
   localparam logic [4:0] EXC_II  = 5'd2;
   localparam logic [4:0] EXC_BK  = 5'd3;
   localparam logic [4:0] EXC_LAF = 5'd5;
   localparam logic [4:0] EXC_SAF = 5'd7;
   localparam logic [4:0] EXC_ECU = 5'd8;
   localparam logic [4:0] EXC_ECS = 5'd9;
   localparam logic [4:0] EXC_ECM = 5'd11;
   localparam logic [4:0] EXC_IPF = 5'd12;
   localparam logic [4:0] EXC_LPF = 5'd13;
   localparam logic [4:0] EXC_SPF = 5'd15;

   localparam logic [4:0] INT_SSI = 5'd1;
   localparam logic [4:0] INT_MSI = 5'd3;
   localparam logic [4:0] INT_STI = 5'd5;
   localparam logic [4:0] INT_MTI = 5'd7;
   localparam logic [4:0] INT_SEI = 5'd9;
   localparam logic [4:0] INT_MEI = 5'd11;

   // 32-bit cause values; interrupts carry bit 31.
   localparam logic [31:0] CAUSE_INT_FLAG = 32'h8000_0000;

   localparam logic [3:0] EB_LAF = 4'd0;
   localparam logic [3:0] EB_SAF = 4'd1;
   localparam logic [3:0] EB_LPF = 4'd2;
   localparam logic [3:0] EB_SPF = 4'd3;
   localparam logic [3:0] EB_BK  = 4'd4;
   localparam logic [3:0] EB_ECU = 4'd5;
   localparam logic [3:0] EB_ECS = 4'd6;
   localparam logic [3:0] EB_ECM = 4'd7;
   localparam logic [3:0] EB_IAM = 4'd8;
   localparam logic [3:0] EB_II  = 4'd9;
   localparam logic [3:0] EB_IAF = 4'd10;
   localparam logic [3:0] EB_IPF = 4'd11;

   localparam logic [2:0] IB_SSI = 3'd0;
   localparam logic [2:0] IB_MSI = 3'd1;
   localparam logic [2:0] IB_STI = 3'd2;
   localparam logic [2:0] IB_MTI = 3'd3;
   localparam logic [2:0] IB_SEI = 3'd4;
   localparam logic [2:0] IB_MEI = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_TAKE = 2'd2
   } trap_state_e;

   function automatic logic [4:0] exc_code(input logic [3:0] idx);
      case (idx)
         EB_IPF:  exc_code = EXC_IPF;
         EB_IAF:  exc_code = EXC_IAF;
         EB_II:   exc_code = EXC_II;
         EB_IAM:  exc_code = EXC_IAM;
         EB_ECM:  exc_code = EXC_ECM;
         EB_ECS:  exc_code = EXC_ECS;
         EB_ECU:  exc_code = EXC_ECU;
         EB_BK:   exc_code = EXC_BK;
         EB_SPF:  exc_code = EXC_SPF;
         EB_LPF:  exc_code = EXC_LPF;
         EB_SAF:  exc_code = EXC_SAF;
         default: exc_code = EXC_LAF;
      endcase
   endfunction

   function automatic logic [4:0] irq_code(input logic [2:0] b);
      case (b)
         IB_MEI:  irq_code = INT_MEI;
         IB_SEI:  irq_code = INT_SEI;
         IB_MTI:  irq_code = INT_MTI;
         IB_STI:  irq_code = INT_STI;
         IB_MSI:  irq_code = INT_MSI;
         default: irq_code = INT_SSI;
      endcase
   endfunction

endpackage

// File: rtl/irq_sync.sv
// One interrupt line: optional SYNC_STAGES-deep synchroniser (TRAP_IRQ_SYNC_EN)
// followed by change detection that emits a one-cycle mip update strobe.
module irq_sync
   import trap_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic line_i,
   output logic mip_in,
   output logic mip_wr
);

   if (SYNC_STAGES < 2) begin : g_bad_depth
      $error("irq_sync: SYNC_STAGES must be at least 2");
   end

   logic line_synced;
   logic in_q, in_d;
   logic wr_q, wr_d;

`ifdef TRAP_IRQ_SYNC_EN
   logic [SYNC_STAGES-1:0] sync_q, sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], line_i};
   end

   always_ff @(posedge clk) begin
      if (!rst) sync_q <= '0;
      else      sync_q <= sync_d;
   end

   assign line_synced = sync_q[SYNC_STAGES-1];
`else
   assign line_synced = line_i;
`endif

   // in_q doubles as the last value reported to the CSR unit.
   always_comb begin
      wr_d = (line_synced != in_q);
      in_d = line_synced;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         in_q <= 1'b0;
         wr_q <= 1'b0;
      end else begin
         in_q <= in_d;
         wr_q <= wr_d;
      end
   end

   assign mip_in = in_q;
   assign mip_wr = wr_q;

endmodule

// File: rtl/trap_ctrl.sv
// Trap arbiter ahead of the CSR unit: exception/interrupt priority, delegation,
// trap handshake FSM and mip strobes. Optional line synchronisers: TRAP_IRQ_SYNC_EN.
module trap_ctrl
   import trap_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int XLEN        = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      statu_cpu,
   input  logic [1:0]      msu,
   input  logic            mie_g,
   input  logic            sie_g,
   input  logic [5:0]      mie_bits,
   input  logic [5:0]      mip_bits,
   input  logic [XLEN-1:0] medeleg,
   input  logic [XLEN-1:0] mideleg,
   input  logic [11:0]     exc_vec,
   input  logic [XLEN-1:0] fault_addr,
   input  logic [XLEN-1:0] inst_word,
   input  logic            irq_m_ext,
   input  logic            irq_s_ext,
   input  logic            irq_m_tmr,
   input  logic            irq_m_sw,
   output logic            trap_req,
   output logic [1:0]      priv_d,
   output logic [XLEN-1:0] cause,
   output logic [XLEN-1:0] tval,
   output logic            meip_in,
   output logic            meip_wr,
   output logic            seip_in,
   output logic            seip_wr,
   output logic            mtip_in,
   output logic            mtip_wr,
   output logic            msip_in,
   output logic            msip_wr
);

   irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mei (
      .clk(clk), .rst(rst), .line_i(irq_m_ext), .mip_in(meip_in), .mip_wr(meip_wr));
   irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sei (
      .clk(clk), .rst(rst), .line_i(irq_s_ext), .mip_in(seip_in), .mip_wr(seip_wr));
   irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mti (
      .clk(clk), .rst(rst), .line_i(irq_m_tmr), .mip_in(mtip_in), .mip_wr(mtip_wr));
   irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_msi (
      .clk(clk), .rst(rst), .line_i(irq_m_sw), .mip_in(msip_in), .mip_wr(msip_wr));

   logic            exc_stage_ok;
   logic            exc_hit;
   logic [3:0]      exc_idx;
   logic [4:0]      exc_cd;
   logic [XLEN-1:0] exc_tval;
   logic [1:0]      exc_priv;

   // Later (higher) set bits overwrite earlier ones, so the MSB wins.
   always_comb begin
      exc_stage_ok = (statu_cpu == ST_IF0)  || (statu_cpu == ST_EX0) ||
                     (statu_cpu == ST_EX1)  || (statu_cpu == ST_MEM0) ||
                     (statu_cpu == ST_MEM1);
      exc_hit = 1'b0;
      exc_idx = EB_LAF;
      for (int i = 0; i < 12; i++) begin
         if (exc_vec[i]) begin
            exc_hit = 1'b1;
            exc_idx = 4'(i);
         end
      end
      exc_cd = exc_code(exc_idx);
      case (exc_idx)
         EB_II:                       exc_tval = inst_word;
         EB_ECM, EB_ECS, EB_ECU, EB_BK: exc_tval = '0;
         default:                     exc_tval = fault_addr;
      endcase
      exc_priv = (medeleg[exc_cd] && (msu != PRIV_M)) ? PRIV_S : PRIV_M;
   end

   logic [5:0] irq_pend;
   logic [5:0] irq_ok;
   logic [5:0] irq_m_tgt;
   logic       irq_hit;
   logic [2:0] irq_sel;
   logic [4:0] irq_cd;
   logic [1:0] irq_priv;

   always_comb begin
      irq_pend  = mip_bits & mie_bits;
      irq_ok    = '0;
      irq_m_tgt = '0;
      for (int b = 0; b < 6; b++) begin
         irq_m_tgt[b] = !mideleg[irq_code(3'(b))] || (msu == PRIV_M);
         if (irq_m_tgt[b])
            irq_ok[b] = irq_pend[b] && ((msu != PRIV_M) || mie_g);
         else
            irq_ok[b] = irq_pend[b] && ((msu == PRIV_U) || ((msu == PRIV_S) && sie_g));
      end
      irq_hit = 1'b1;
      irq_sel = IB_MEI;
      if (irq_ok[IB_MEI])      irq_sel = IB_MEI;
      else if (irq_ok[IB_MSI]) irq_sel = IB_MSI;
      else if (irq_ok[IB_MTI]) irq_sel = IB_MTI;
      else if (irq_ok[IB_SEI]) irq_sel = IB_SEI;
      else if (irq_ok[IB_SSI]) irq_sel = IB_SSI;
      else if (irq_ok[IB_STI]) irq_sel = IB_STI;
      else                     irq_hit = 1'b0;
      irq_cd   = irq_code(irq_sel);
      irq_priv = irq_m_tgt[irq_sel] ? PRIV_M : PRIV_S;
   end

   trap_state_e     state_q, state_d;
   logic            trap_req_q, trap_req_d;
   logic [1:0]      trap_priv_q, trap_priv_d;
   logic [XLEN-1:0] cause_q, cause_d;
   logic [XLEN-1:0] tval_q, tval_d;

   // Captured values stay frozen outside IDLE; nothing arriving meanwhile is queued.
   always_comb begin
      state_d     = state_q;
      trap_req_d  = trap_req_q;
      trap_priv_d = trap_priv_q;
      cause_d     = cause_q;
      tval_d      = tval_q;
      case (state_q)
         S_IDLE: begin
            if (exc_stage_ok && exc_hit) begin
               state_d     = S_REQ;
               trap_req_d  = 1'b1;
               trap_priv_d = exc_priv;
               cause_d     = {{(XLEN-5){1'b0}}, exc_cd};
               tval_d      = exc_tval;
            end else if ((statu_cpu == ST_IF0) && irq_hit) begin
               state_d     = S_REQ;
               trap_req_d  = 1'b1;
               trap_priv_d = irq_priv;
               cause_d     = {1'b1, {(XLEN-6){1'b0}}, irq_cd};
               tval_d      = '0;
            end
         end
         S_REQ: begin
            if (statu_cpu == ST_EXC) begin
               state_d    = S_TAKE;
               trap_req_d = 1'b0;
            end
         end
         S_TAKE: begin
            if (statu_cpu != ST_EXC) state_d = S_IDLE;
         end
         default: begin
            state_d    = S_IDLE;
            trap_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         trap_req_q  <= 1'b0;
         trap_priv_q <= PRIV_U;
         cause_q     <= '0;
         tval_q      <= '0;
      end else begin
         state_q     <= state_d;
         trap_req_q  <= trap_req_d;
         trap_priv_q <= trap_priv_d;
         cause_q     <= cause_d;
         tval_q      <= tval_d;
      end
   end

   assign trap_req = trap_req_q;
   assign priv_d   = trap_priv_q;
   assign cause    = cause_q;
   assign tval     = tval_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: vector table for capture/priority/delegation plus
// hand sequences for reset, handshake and mip strobes (TRAP_IRQ_SYNC_EN aware).
module tb_trap_ctrl;

   localparam int XLEN = 32;
   localparam int SYNC = 2;
`ifdef TRAP_IRQ_SYNC_EN
   localparam int IRQ_LAT = SYNC + 1;
`else
   localparam int IRQ_LAT = 1;
`endif
   localparam logic [31:0] IWORD = 32'h1234_5678;

   logic            clk;
   logic            rst;
   logic [3:0]      statu_cpu;
   logic [1:0]      msu;
   logic            mie_g, sie_g;
   logic [5:0]      mie_bits, mip_bits;
   logic [XLEN-1:0] medeleg, mideleg;
   logic [11:0]     exc_vec;
   logic [XLEN-1:0] fault_addr, inst_word;
   logic [3:0]      irq_lines;
   logic            trap_req;
   logic [1:0]      priv_d;
   logic [XLEN-1:0] cause, tval;
   logic            meip_in, meip_wr, seip_in, seip_wr;
   logic            mtip_in, mtip_wr, msip_in, msip_wr;

   logic [3:0] wr_v, in_v;
   assign wr_v = {meip_wr, seip_wr, mtip_wr, msip_wr};
   assign in_v = {meip_in, seip_in, mtip_in, msip_in};

   int checks = 0;
   int errors = 0;

   trap_ctrl #(.SYNC_STAGES(SYNC), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .statu_cpu(statu_cpu), .msu(msu),
      .mie_g(mie_g), .sie_g(sie_g), .mie_bits(mie_bits), .mip_bits(mip_bits),
      .medeleg(medeleg), .mideleg(mideleg), .exc_vec(exc_vec),
      .fault_addr(fault_addr), .inst_word(inst_word),
      .irq_m_ext(irq_lines[3]), .irq_s_ext(irq_lines[2]),
      .irq_m_tmr(irq_lines[1]), .irq_m_sw(irq_lines[0]),
      .trap_req(trap_req), .priv_d(priv_d), .cause(cause), .tval(tval),
      .meip_in(meip_in), .meip_wr(meip_wr), .seip_in(seip_in), .seip_wr(seip_wr),
      .mtip_in(mtip_in), .mtip_wr(mtip_wr), .msip_in(msip_in), .msip_wr(msip_wr));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  statu;
      logic [1:0]  msu;
      logic        mie_g;
      logic        sie_g;
      logic [5:0]  mie;
      logic [5:0]  mip;
      logic [31:0] medeleg;
      logic [31:0] mideleg;
      logic [11:0] exc;
      logic [31:0] faddr;
      logic        trap;
      logic [1:0]  priv;
      logic [31:0] cause;
      logic [31:0] tval;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs[NV];

   function automatic vec_t mkv(input logic [3:0] st, input logic [1:0] m, input logic mg,
                                input logic sg, input logic [5:0] ie, input logic [5:0] ip,
                                input logic [31:0] med, input logic [31:0] mid,
                                input logic [11:0] ex, input logic [31:0] fa, input logic tr,
                                input logic [1:0] pv, input logic [31:0] ca, input logic [31:0] tv);
      vec_t v;
      v.statu = st; v.msu = m; v.mie_g = mg; v.sie_g = sg; v.mie = ie; v.mip = ip;
      v.medeleg = med; v.mideleg = mid; v.exc = ex; v.faddr = fa;
      v.trap = tr; v.priv = pv; v.cause = ca; v.tval = tv;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      statu_cpu = 4'b0000; msu = 2'b11; mie_g = 1'b0; sie_g = 1'b0;
      mie_bits = '0; mip_bits = '0; medeleg = '0; mideleg = '0;
      exc_vec = '0; fault_addr = 32'hDEAD_BEEF; inst_word = IWORD;
   endtask

   task automatic apply_stimulus(input vec_t v);
      statu_cpu = v.statu; msu = v.msu; mie_g = v.mie_g; sie_g = v.sie_g;
      mie_bits = v.mie; mip_bits = v.mip; medeleg = v.medeleg; mideleg = v.mideleg;
      exc_vec = v.exc; fault_addr = v.faddr; inst_word = IWORD;
   endtask

   task automatic check_output(input string tag, input logic tr, input logic [1:0] pv,
                               input logic [31:0] ca, input logic [31:0] tv);
      check({tag, ".trap_req"}, 32'(trap_req), 32'(tr));
      check({tag, ".priv_d"}, 32'(priv_d), 32'(pv));
      check({tag, ".cause"}, cause, ca);
      check({tag, ".tval"}, tval, tv);
   endtask

   // Walk the trap back to IDLE through the exc state with nothing new pending.
   task automatic finish_trap(input string tag);
      exc_vec = '0; mie_bits = '0; mip_bits = '0;
      statu_cpu = 4'b1111;
      step();
      check({tag, ".req_drop"}, 32'(trap_req), 32'd0);
      statu_cpu = 4'b0000;
      step();
   endtask

   task automatic irq_edge_check(input int k, input logic val, input logic [3:0] prev_in);
      logic [3:0] onehot, exp_in;
      onehot = 4'b0001 << k;
      irq_lines[k] = val;
      for (int c = 1; c <= IRQ_LAT + 1; c++) begin
         step();
         exp_in = (c >= IRQ_LAT) ? (val ? (prev_in | onehot) : (prev_in & ~onehot)) : prev_in;
         check($sformatf("irq%0d_v%0d_c%0d.wr", k, val, c), 32'(wr_v),
               32'((c == IRQ_LAT) ? onehot : 4'b0000));
         check($sformatf("irq%0d_v%0d_c%0d.in", k, val, c), 32'(in_v), 32'(exp_in));
      end
   endtask

   initial begin
      vecs[0]  = mkv(4'b0010, 2'b00, 0, 0, 6'h00, 6'h00, 32'h0,    32'h0,   12'h006, 32'h8000_1004, 1, 2'b11, 32'h0000_000D, 32'h8000_1004);
      vecs[1]  = mkv(4'b0001, 2'b00, 0, 0, 6'h00, 6'h00, 32'h100,  32'h0,   12'h020, 32'hDEAD_BEEF, 1, 2'b01, 32'h0000_0008, 32'h0);
      vecs[2]  = mkv(4'b0001, 2'b11, 0, 0, 6'h00, 6'h00, 32'h900,  32'h0,   12'h080, 32'hDEAD_BEEF, 1, 2'b11, 32'h0000_000B, 32'h0);
      vecs[3]  = mkv(4'b1001, 2'b01, 0, 0, 6'h00, 6'h00, 32'h4,    32'h0,   12'h201, 32'hDEAD_BEEF, 1, 2'b01, 32'h0000_0002, IWORD);
      vecs[4]  = mkv(4'b0000, 2'b11, 0, 0, 6'h00, 6'h00, 32'h1000, 32'h0,   12'hFFF, 32'h0000_4000, 1, 2'b11, 32'h0000_000C, 32'h0000_4000);
      vecs[5]  = mkv(4'b0011, 2'b00, 0, 0, 6'h00, 6'h00, 32'h0,    32'h0,   12'h400, 32'hDEAD_BEEF, 0, 2'b00, 32'h0,         32'h0);
      vecs[6]  = mkv(4'b0000, 2'b11, 0, 0, 6'h08, 6'h08, 32'h0,    32'h0,   12'h000, 32'hDEAD_BEEF, 0, 2'b00, 32'h0,         32'h0);
      vecs[7]  = mkv(4'b0000, 2'b11, 1, 0, 6'h08, 6'h08, 32'h0,    32'h0,   12'h000, 32'hDEAD_BEEF, 1, 2'b11, 32'h8000_0007, 32'h0);
      vecs[8]  = mkv(4'b0000, 2'b11, 1, 0, 6'h28, 6'h28, 32'h0,    32'h0,   12'h000, 32'hDEAD_BEEF, 1, 2'b11, 32'h8000_000B, 32'h0);
      vecs[9]  = mkv(4'b0001, 2'b11, 1, 0, 6'h08, 6'h08, 32'h0,    32'h0,   12'h000, 32'hDEAD_BEEF, 0, 2'b00, 32'h0,         32'h0);
      vecs[10] = mkv(4'b0000, 2'b00, 0, 0, 6'h14, 6'h14, 32'h0,    32'h200, 12'h000, 32'hDEAD_BEEF, 1, 2'b01, 32'h8000_0009, 32'h0);
      vecs[11] = mkv(4'b0000, 2'b01, 0, 0, 6'h03, 6'h03, 32'h0,    32'h222, 12'h000, 32'hDEAD_BEEF, 1, 2'b11, 32'h8000_0003, 32'h0);
      vecs[12] = mkv(4'b0000, 2'b01, 0, 0, 6'h01, 6'h01, 32'h0,    32'h222, 12'h000, 32'hDEAD_BEEF, 0, 2'b00, 32'h0,         32'h0);
      vecs[13] = mkv(4'b0000, 2'b01, 0, 1, 6'h01, 6'h01, 32'h0,    32'h222, 12'h000, 32'hDEAD_BEEF, 1, 2'b01, 32'h8000_0001, 32'h0);
      vecs[14] = mkv(4'b0000, 2'b00, 0, 0, 6'h00, 6'h3F, 32'h0,    32'h0,   12'h000, 32'hDEAD_BEEF, 0, 2'b00, 32'h0,         32'h0);
      vecs[15] = mkv(4'b0000, 2'b11, 1, 0, 6'h20, 6'h20, 32'h0,    32'h0,   12'h010, 32'hDEAD_BEEF, 1, 2'b11, 32'h0000_0003, 32'h0);
      vecs[16] = mkv(4'b0010, 2'b01, 0, 0, 6'h00, 6'h00, 32'h2000, 32'h0,   12'h004, 32'h1000_0000, 1, 2'b01, 32'h0000_000D, 32'h1000_0000);
      vecs[17] = mkv(4'b0000, 2'b11, 1, 0, 6'h20, 6'h20, 32'h0,    32'h800, 12'h000, 32'hDEAD_BEEF, 1, 2'b11, 32'h8000_000B, 32'h0);

      // Reset with the external M line already high.
      idle_inputs();
      irq_lines = 4'b1000;
      rst = 1'b0;
      step();
      step();
      check_output("reset", 1'b0, 2'b00, 32'h0, 32'h0);
      check("reset.wr", 32'(wr_v), 32'h0);
      check("reset.in", 32'(in_v), 32'h0);
      rst = 1'b1;
      for (int c = 1; c <= IRQ_LAT + 2; c++) begin
         step();
         check($sformatf("rel_c%0d.meip_wr", c), 32'(meip_wr), 32'(c == IRQ_LAT));
         check($sformatf("rel_c%0d.meip_in", c), 32'(meip_in), 32'(c >= IRQ_LAT));
         check($sformatf("rel_c%0d.seip_wr", c), 32'(seip_wr), 32'd0);
      end
      irq_edge_check(3, 1'b0, 4'b1000);
      for (int k = 2; k >= 0; k--) begin
         irq_edge_check(k, 1'b1, 4'b0000);
         irq_edge_check(k, 1'b0, 4'b0001 << k);
      end

      // Table-driven capture, priority and delegation.
      for (int i = 0; i < NV; i++) begin
         apply_stimulus(vecs[i]);
         step();
         check($sformatf("v%0d.trap_req", i), 32'(trap_req), 32'(vecs[i].trap));
         if (vecs[i].trap) begin
            check($sformatf("v%0d.priv_d", i), 32'(priv_d), 32'(vecs[i].priv));
            check($sformatf("v%0d.cause", i), cause, vecs[i].cause);
            check($sformatf("v%0d.tval", i), tval, vecs[i].tval);
            finish_trap($sformatf("v%0d", i));
         end else begin
            idle_inputs();
         end
      end

      // Handshake: REQ held while a new ii is ignored, then exc drops trap_req.
      idle_inputs();
      msu = 2'b00; statu_cpu = 4'b0010; exc_vec = 12'h004; fault_addr = 32'h8000_2000;
      step();
      check_output("hs_cap", 1'b1, 2'b11, 32'hD, 32'h8000_2000);
      exc_vec = 12'h200; statu_cpu = 4'b0000;
      for (int c = 0; c < 5; c++) begin
         step();
         check_output($sformatf("hs_hold%0d", c), 1'b1, 2'b11, 32'hD, 32'h8000_2000);
      end
      statu_cpu = 4'b1111;
      step();
      check_output("hs_exc1", 1'b0, 2'b11, 32'hD, 32'h8000_2000);
      step();
      check_output("hs_exc2", 1'b0, 2'b11, 32'hD, 32'h8000_2000);
      statu_cpu = 4'b0000;
      step();
      check_output("hs_idle", 1'b0, 2'b11, 32'hD, 32'h8000_2000);
      step();
      check_output("hs_ii", 1'b1, 2'b11, 32'h2, IWORD);
      finish_trap("hs_ii");

      // Reset while a trap is being requested, then a fresh exception.
      idle_inputs();
      msu = 2'b00; statu_cpu = 4'b0001; exc_vec = 12'h020;
      step();
      check_output("mid_cap", 1'b1, 2'b11, 32'h8, 32'h0);
      rst = 1'b0;
      step();
      check_output("mid_rst", 1'b0, 2'b00, 32'h0, 32'h0);
      rst = 1'b1;
      statu_cpu = 4'b0010; exc_vec = 12'h001; fault_addr = 32'hA5A5_0000;
      step();
      check_output("mid_new", 1'b1, 2'b11, 32'h5, 32'hA5A5_0000);
      finish_trap("mid_new");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
